serial_mem_responder: RTL and testbench



---
 rtl/serial_link_pkg.sv | 19 +
 rtl/serial_mem_responder_if.sv | 22 ++
 rtl/serial_mem_responder_line_sram.sv | 27 ++
 rtl/serial_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_serial_mem_responder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_link_pkg.sv
// Constants and state encoding shared by both ends of the 16-bit serial cache-line link.
package serial_link_pkg;

  localparam int BEAT_COUNT = 8;
  localparam int BEAT_W     = 16;
  localparam int LINE_BITS  = BEAT_COUNT * BEAT_W;
  localparam int BEAT_IDX_W = 3;

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RD_BURST = 3'd3,
    ST_RD_GAP   = 3'd4
  } link_state_e;

endpackage

// File: rtl/serial_mem_responder_if.sv
// Requester-facing signals of the serial cache-line link.
interface serial_mem_responder_if;

  logic                               is_write;
  logic [63:0]                        addr;
  logic [serial_link_pkg::BEAT_W-1:0] d_out;
  logic                               d_out_valid;
  logic                               rd_pending;
  logic [serial_link_pkg::BEAT_W-1:0] d_in;
  logic                               d_in_valid;

  modport master (
    output is_write, addr, d_out, d_out_valid, rd_pending,
    input  d_in, d_in_valid
  );

  modport slave (
    input  is_write, addr, d_out, d_out_valid, rd_pending,
    output d_in, d_in_valid
  );

endinterface

// File: rtl/serial_mem_responder_line_sram.sv
// Single-port synchronous word RAM addressed by {line, beat}; read data is registered
// and returns the contents before any write on the same edge.
module line_sram
  import serial_link_pkg::*;
#(
  parameter int LG_LINES = 10
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [LG_LINES+BEAT_IDX_W-1:0] addr,
  input  logic [BEAT_W-1:0]              wr_data,
  output logic [BEAT_W-1:0]              rd_data
);

  localparam int DEPTH = 1 << (LG_LINES + BEAT_IDX_W);

  logic [BEAT_W-1:0] mem_r [0:DEPTH-1];

  // Storage array with registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wr_data;
    end
    rd_data <= mem_r[addr];
  end

endmodule

// File: rtl/serial_mem_responder.sv
// Memory-side endpoint of the serial cache-line link: stores eight-beat write bursts
// into a line SRAM and answers read requests with eight-beat bursts after a fixed wait.
module serial_mem_responder
  import serial_link_pkg::*;
#(
  parameter int LG_LINES    = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_mem_responder_if.slave link,
  output logic                  busy,
  output logic                  err,
  output logic [31:0]           wr_lines,
  output logic [31:0]           rd_lines
);

  localparam int         AW        = LG_LINES + BEAT_IDX_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  link_state_e           state_r, state_s;
  logic [BEAT_IDX_W-1:0] beat_r, beat_s;
  logic [3:0]            wait_r, wait_s;
  logic [LG_LINES-1:0]   base_r, base_s, addr_line_s;
  logic                  err_r, err_evt_s;
  logic                  wr_inc_s, rd_inc_s, mem_we_s, sram_we_s, d_in_valid_s;
  logic                  busy_r, d_in_valid_r;
  logic [BEAT_W-1:0]     d_in_r, sram_rd_s;
  logic [AW-1:0]         mem_addr_s;
  logic [31:0]           wr_lines_r, rd_lines_r;
  logic                  addr_unused_s;

  assign addr_line_s   = link.addr[LG_LINES+3:4];
  assign addr_unused_s = ^{link.addr[63:LG_LINES+4], link.addr[3:0]};
  assign sram_we_s     = mem_we_s & ~reset;

  line_sram #(.LG_LINES(LG_LINES)) u_line_sram (
    .clk     (clk),
    .we      (sram_we_s),
    .addr    (mem_addr_s),
    .wr_data (link.d_out),
    .rd_data (sram_rd_s)
  );

  // Next-state, SRAM control and protocol-error detection
  always_comb begin
    state_s      = state_r;
    beat_s       = beat_r;
    wait_s       = wait_r;
    base_s       = base_r;
    err_evt_s    = 1'b0;
    wr_inc_s     = 1'b0;
    rd_inc_s     = 1'b0;
    mem_we_s     = 1'b0;
    d_in_valid_s = 1'b0;
    mem_addr_s   = {base_r, beat_r};
    case (state_r)
      ST_IDLE: begin
        mem_addr_s = {addr_line_s, 3'd0};
        if (link.d_out_valid) begin
          mem_we_s  = 1'b1;
          base_s    = addr_line_s;
          beat_s    = 3'd1;
          state_s   = ST_WR;
          err_evt_s = link.rd_pending;
        end else if (link.rd_pending && !link.is_write) begin
          base_s  = addr_line_s;
          wait_s  = WAIT_INIT;
          state_s = ST_RD_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR: begin
        err_evt_s = link.rd_pending;
        if (link.d_out_valid) begin
          mem_we_s = 1'b1;
          beat_s   = beat_r + 3'd1;
          if (beat_r == LAST_BEAT) begin
            wr_inc_s = 1'b1;
            state_s  = ST_IDLE;
          end else begin
            state_s = ST_WR;
          end
        end else begin
          state_s = ST_WR;
        end
      end
      // RD_WAIT always lasts at least one cycle: it primes the registered SRAM read of word 0,
      // which keeps first-beat latency at WAIT_CYCLES+2 even for a zero wait.
      ST_RD_WAIT: begin
        mem_addr_s = {base_r, 3'd0};
        err_evt_s  = link.d_out_valid;
        if (!link.rd_pending) begin
          err_evt_s = 1'b1;
          beat_s    = 3'd0;
          state_s   = ST_IDLE;
        end else if (wait_r == 4'd0) begin
          beat_s  = 3'd0;
          state_s = ST_RD_BURST;
        end else begin
          wait_s = wait_r - 4'd1;
        end
      end
      ST_RD_BURST: begin
        mem_addr_s = {base_r, beat_r + 3'd1};
        err_evt_s  = link.d_out_valid;
        if (!link.rd_pending) begin
          err_evt_s = 1'b1;
          beat_s    = 3'd0;
          state_s   = ST_IDLE;
        end else begin
          d_in_valid_s = 1'b1;
          beat_s       = beat_r + 3'd1;
          if (beat_r == LAST_BEAT) begin
            rd_inc_s = 1'b1;
            state_s  = ST_RD_GAP;
          end else begin
            state_s = ST_RD_BURST;
          end
        end
      end
      ST_RD_GAP: begin
        err_evt_s = link.d_out_valid;
        state_s   = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered link outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      beat_r       <= 3'd0;
      wait_r       <= 4'd0;
      base_r       <= '0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      d_in_r       <= 16'd0;
      d_in_valid_r <= 1'b0;
      wr_lines_r   <= 32'd0;
      rd_lines_r   <= 32'd0;
    end else begin
      state_r      <= state_s;
      beat_r       <= beat_s;
      wait_r       <= wait_s;
      base_r       <= base_s;
      err_r        <= err_r | err_evt_s;
      busy_r       <= (state_s != ST_IDLE);
      d_in_r       <= d_in_valid_s ? sram_rd_s : 16'd0;
      d_in_valid_r <= d_in_valid_s;
      wr_lines_r   <= wr_lines_r + {31'd0, wr_inc_s};
      rd_lines_r   <= rd_lines_r + {31'd0, rd_inc_s};
    end
  end

  assign link.d_in       = d_in_r;
  assign link.d_in_valid = d_in_valid_r;
  assign busy            = busy_r;
  assign err             = err_r;
  assign wr_lines        = wr_lines_r;
  assign rd_lines        = rd_lines_r;

endmodule

// File: tb/tb_serial_mem_responder.sv
// Directed plus randomized bench for serial_mem_responder, checked against a line-array model.
module tb_serial_mem_responder;

  localparam int LG = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_write, d_out_valid, rd_pending, rd_pending0;
  logic [63:0] addr;
  logic [15:0] d_out;
  logic        busy, err, busy0, err0;
  logic [31:0] wr_lines, rd_lines, wr_lines0, rd_lines0;

  serial_mem_responder_if bus ();
  serial_mem_responder_if bus0 ();

  assign bus.is_write     = is_write;
  assign bus.addr         = addr;
  assign bus.d_out        = d_out;
  assign bus.d_out_valid  = d_out_valid;
  assign bus.rd_pending   = rd_pending;
  assign bus0.is_write    = is_write;
  assign bus0.addr        = addr;
  assign bus0.d_out       = d_out;
  assign bus0.d_out_valid = d_out_valid;
  assign bus0.rd_pending  = rd_pending0;

  serial_mem_responder #(.LG_LINES(LG), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .link(bus),
    .busy(busy), .err(err), .wr_lines(wr_lines), .rd_lines(rd_lines)
  );

  serial_mem_responder #(.LG_LINES(LG), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .link(bus0),
    .busy(busy0), .err(err0), .wr_lines(wr_lines0), .rd_lines(rd_lines0)
  );

  always #5 clk = ~clk;

  // Reference: whole lines as plain 128-bit values, word k in bits [16k+15:16k]
  logic [127:0] model_mem [0:(1<<LG)-1];
  logic [31:0]  exp_wr, exp_rd;
  logic         exp_err;
  int           n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; d_out_valid = 1'b0; rd_pending = 1'b0; rd_pending0 = 1'b0; is_write = 1'b0;
    @(negedge clk);
    check("rst_d_in", {16'd0, bus.d_in}, 32'd0);
    check("rst_d_in_valid", {31'd0, bus.d_in_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_wr_lines", wr_lines, 32'd0);
    check("rst_rd_lines", rd_lines, 32'd0);
    reset = 1'b0;
    exp_err = 1'b0; exp_wr = 32'd0; exp_rd = 32'd0;
  endtask

  // gap >= 0: fixed idle cycles between beats; -1: 0,1,3 pattern; -2: random 0..3
  task automatic write_line(input logic [63:0] a, input logic [127:0] data, input int gap, input int nbeats);
    logic [LG-1:0] ln;
    int g;
    ln = a[LG+3:4];
    for (int k = 0; k < nbeats; k++) begin
      addr = a; is_write = 1'b1; d_out = data[16*k +: 16]; d_out_valid = 1'b1;
      @(negedge clk);
      model_mem[ln][16*k +: 16] = data[16*k +: 16];
      d_out_valid = 1'b0;
      check("wr_busy", {31'd0, busy}, (k < 7) ? 32'd1 : 32'd0);
      if (gap >= 0) g = gap;
      else if (gap == -1) g = (k % 3 == 0) ? 0 : ((k % 3 == 1) ? 1 : 3);
      else g = int'($urandom_range(0, 3));
      if (k < 7) repeat (g) @(negedge clk);
    end
    is_write = 1'b0;
    if (nbeats == 8) begin
      exp_wr = exp_wr + 32'd1;
      check("wr_lines", wr_lines, exp_wr);
      check("wr_err", {31'd0, err}, {31'd0, exp_err});
    end
  endtask

  task automatic read_line(input logic [63:0] a, input int sel, input int wait_c,
                           input int abort_after, input int pulse_at);
    logic [127:0] exp_line;
    logic         vld;
    logic [15:0]  dat;
    int           lat;
    bit           got, aborted;
    exp_line = model_mem[a[LG+3:4]];
    addr = a; is_write = 1'b0;
    if (sel == 0) rd_pending = 1'b1; else rd_pending0 = 1'b1;
    lat = 0; got = 1'b0; aborted = 1'b0;
    for (int j = 0; j < 40 && !got; j++) begin
      @(negedge clk);
      vld = (sel == 0) ? bus.d_in_valid : bus0.d_in_valid;
      if (vld) got = 1'b1; else lat++;
    end
    check("rd_start", {31'd0, got}, 32'd1);
    if (got) begin
      check("rd_latency", 32'(lat), 32'(wait_c + 2));
      for (int k = 0; k < 8 && !aborted; k++) begin
        if (k > 0) @(negedge clk);
        d_out_valid = 1'b0;
        vld = (sel == 0) ? bus.d_in_valid : bus0.d_in_valid;
        dat = (sel == 0) ? bus.d_in : bus0.d_in;
        check("rd_valid", {31'd0, vld}, 32'd1);
        check("rd_data", {16'd0, dat}, {16'd0, exp_line[16*k +: 16]});
        if (k == pulse_at) begin
          d_out = 16'hDEAD; d_out_valid = 1'b1; exp_err = 1'b1;
        end
        if (k + 1 == abort_after) aborted = 1'b1;
      end
    end
    rd_pending = 1'b0; rd_pending0 = 1'b0; d_out_valid = 1'b0;
    @(negedge clk);
    vld = (sel == 0) ? bus.d_in_valid : bus0.d_in_valid;
    check("rd_valid_drop", {31'd0, vld}, 32'd0);
    if (sel == 0) begin
      if (aborted) exp_err = 1'b1;
      else if (got) exp_rd = exp_rd + 32'd1;
      check("rd_lines", rd_lines, exp_rd);
      check("rd_err", {31'd0, err}, {31'd0, exp_err});
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] line_data;
    logic [63:0]  a;
    addr = 64'd0; d_out = 16'd0; is_write = 1'b0; d_out_valid = 1'b0;
    rd_pending = 1'b0; rd_pending0 = 1'b0; reset = 1'b1;
    do_reset();

    // Basic line write and read with a two-cycle wait
    line_data = {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    write_line(64'h400, line_data, 0, 8);
    read_line(64'h400, 0, 2, 0, -1);

    // Zero-wait instance saw the same write stream
    read_line(64'h400, 1, 0, 0, -1);

    // Gapped write stream
    line_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    write_line(64'h7F0, line_data, -1, 8);
    read_line(64'h7F0, 0, 2, 0, -1);

    // Unaligned address with junk upper bits lands on line 0x40
    line_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    write_line(64'hABCD_0000_0000_040A, line_data, 0, 8);
    read_line(64'h400, 0, 2, 0, -1);

    // Abort after three beats, then a normal write
    read_line(64'h7F0, 0, 2, 3, -1);
    line_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    write_line(64'h1230, line_data, 1, 8);
    read_line(64'h1230, 0, 2, 0, -1);

    // Stray write strobe during a read burst: flagged, memory untouched
    do_reset();
    read_line(64'h400, 0, 2, 0, 2);
    read_line(64'h400, 0, 2, 0, -1);

    // Reset in the middle of a write keeps the words already stored
    do_reset();
    line_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    write_line(64'h7F0, line_data, 0, 4);
    do_reset();
    read_line(64'h7F0, 0, 2, 0, -1);

    for (int i = 0; i < 6; i++) begin
      a = {$urandom(), $urandom()};
      line_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      write_line(a, line_data, -2, 8);
      read_line(a ^ 64'h5, 0, 2, 0, -1);
    end

    // Write counter wraps past all-ones
    dut.wr_lines_r = 32'hFFFF_FFFF;
    exp_wr = 32'hFFFF_FFFF;
    line_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    write_line(64'h2000, line_data, 0, 8);
    check("wr_wrap_zero", wr_lines, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
